fruit_pool: RTL and testbench

FRUIT_POOL -- requirements
Module: fruit_pool

---
 rtl/fruit_pool.sv | 134 +++++++++++++
 tb/tb_fruit_pool.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_pool.sv
// fruit_pool: fixed pool of ballistic fruit slots with launch, slice detection,
// miss/cut scoring and a level-driven gravity that rises with the cut total.
module fruit_pool #(
  parameter int NUM_FRUITS  = 4,
  parameter int POS_W       = 11,
  parameter int VEL_W       = 8,
  parameter int GRAVITY     = 1,
  parameter int GRAVITY_MAX = 4,
  parameter int LEVEL_SHIFT = 3,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int FRUIT_SIZE  = 4,
  parameter int CUT_FRAMES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic                        launch_valid,
  output logic                        launch_ready,
  input  logic [POS_W-1:0]            launch_x,
  input  logic [VEL_W-1:0]            launch_vx,
  input  logic [VEL_W-1:0]            launch_vy,
  input  logic                        cut_valid,
  input  logic [POS_W-1:0]            cut_x,
  input  logic [POS_W-1:0]            cut_y,
  output logic [NUM_FRUITS*POS_W-1:0] fruit_x,
  output logic [NUM_FRUITS*POS_W-1:0] fruit_y,
  output logic [NUM_FRUITS-1:0]       fruit_active,
  output logic [NUM_FRUITS-1:0]       fruit_cut,
  output logic [9:0]                  fruit_s,
  output logic [CNT_W-1:0]            cut_count,
  output logic [CNT_W-1:0]            miss_count,
  output logic [3:0]                  gravity
);
  localparam int TW = $clog2(CUT_FRAMES + 1);
  localparam int HW = $clog2(NUM_FRUITS + 1);
  localparam logic signed [POS_W:0] XM = (POS_W+1)'(X_MAX);
  localparam logic signed [POS_W:0] YM = (POS_W+1)'(Y_MAX);
  localparam logic signed [POS_W:0] FS = (POS_W+1)'(FRUIT_SIZE);
  localparam logic signed [VEL_W:0] VMAX = (VEL_W+1)'(2**(VEL_W-1) - 1);
  localparam logic [3:0] G0 = 4'(GRAVITY);
  localparam logic [3:0] GMAX = 4'(GRAVITY_MAX);

  typedef enum logic [1:0] {IDLE, FLYING, CUT} state_t;

  logic [NUM_FRUITS-1:0] idle, sel, hit_v, miss_v;
  logic [HW-1:0] hits, misses;
  logic [CNT_W:0] cut_sum, miss_sum, gsum;
  logic accept;

  assign fruit_s = 10'(FRUIT_SIZE);
  assign launch_ready = |idle;
  assign accept = launch_valid & launch_ready;
  // one-hot of the lowest IDLE slot
  assign sel = idle & (~idle + NUM_FRUITS'(1));

  for (genvar i = 0; i < NUM_FRUITS; i++) begin : g_slot
    state_t st, st_n;
    logic signed [POS_W-1:0] x, y;
    logic signed [VEL_W-1:0] vx, vy;
    logic [TW-1:0] tmr;
    logic signed [POS_W:0] nx, ny, dx, dy;
    logic signed [VEL_W:0] vs;
    logic load, hit, ext;
    assign nx = (POS_W+1)'(x) + (POS_W+1)'(vx);
    assign ny = (POS_W+1)'(y) + (POS_W+1)'(vy);
    assign vs = (VEL_W+1)'(vy) + (VEL_W+1)'($signed({1'b0, gravity}));
    assign dx = (POS_W+1)'(x) - (POS_W+1)'($signed(cut_x));
    assign dy = (POS_W+1)'(y) - (POS_W+1)'($signed(cut_y));
    assign load = accept & sel[i];
    assign hit = st == FLYING && cut_valid && dx <= FS && dx >= -FS && dy <= FS && dy >= -FS;
    assign ext = st == FLYING && !hit &&
                 ((ny > YM && !vy[VEL_W-1] && vy != '0) || nx[POS_W] || nx > XM);
    assign idle[i] = st == IDLE;
    assign hit_v[i] = hit;
    assign miss_v[i] = ext;
    assign fruit_active[i] = st == FLYING;
    assign fruit_cut[i] = st == CUT;
    assign fruit_x[i*POS_W +: POS_W] = st == IDLE ? '0 : x;
    assign fruit_y[i*POS_W +: POS_W] = st == IDLE ? '0 : y;
    always_comb
      st_n = st == IDLE   ? (load ? FLYING : IDLE) :
             st == FLYING ? (hit ? CUT : ext ? IDLE : FLYING) :
                            (tmr == '0 ? IDLE : CUT);
    always_ff @(posedge frame_clk) begin
      if (Reset) begin
        st  <= IDLE;
        x   <= '0;
        y   <= '0;
        vx  <= '0;
        vy  <= '0;
        tmr <= '0;
      end else begin
        st  <= st_n;
        tmr <= hit ? TW'(CUT_FRAMES - 1) : st == CUT ? tmr - TW'(1) : tmr;
        if (load) begin
          x  <= $signed(launch_x);
          y  <= YM[POS_W-1:0];
          vx <= $signed(launch_vx);
          vy <= $signed(launch_vy);
        end else if (st == FLYING && !hit && !ext) begin
          x  <= nx[POS_W-1:0];
          y  <= ny[POS_W-1:0];
          vy <= vs > VMAX ? VMAX[VEL_W-1:0] : vs[VEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    hits = '0;
    misses = '0;
    for (int i = 0; i < NUM_FRUITS; i++) begin
      hits = hits + HW'(hit_v[i]);
      misses = misses + HW'(miss_v[i]);
    end
  end

  assign cut_sum  = {1'b0, cut_count} + (CNT_W+1)'(hits);
  assign miss_sum = {1'b0, miss_count} + (CNT_W+1)'(misses);
  assign gsum     = (CNT_W+1)'(G0) + (CNT_W+1)'(cut_count >> LEVEL_SHIFT);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      cut_count  <= '0;
      miss_count <= '0;
      gravity    <= G0;
    end else begin
      cut_count  <= cut_sum[CNT_W] ? '1 : cut_sum[CNT_W-1:0];
      miss_count <= miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
      gravity    <= gsum > (CNT_W+1)'(GMAX) ? GMAX : gsum[3:0];
    end
  end
endmodule

// File: tb/tb_fruit_pool.sv
// tb_fruit_pool: directed vectors and hand-computed sequences for fruit_pool.
module tb_fruit_pool;
  logic frame_clk = 0;
  logic Reset, launch_valid, cut_valid, launch_ready;
  logic [10:0] launch_x, cut_x, cut_y;
  logic [7:0] launch_vx, launch_vy, cut_count, miss_count;
  logic [43:0] fruit_x, fruit_y;
  logic [3:0] fruit_active, fruit_cut, gravity;
  logic [9:0] fruit_s;
  int checks = 0, errors = 0;

  typedef struct { int dx; int dy; int hit; } vec_t;
  vec_t vecs[8];

  fruit_pool dut (
    .frame_clk(frame_clk), .Reset(Reset), .launch_valid(launch_valid),
    .launch_ready(launch_ready), .launch_x(launch_x), .launch_vx(launch_vx),
    .launch_vy(launch_vy), .cut_valid(cut_valid), .cut_x(cut_x), .cut_y(cut_y),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_active(fruit_active),
    .fruit_cut(fruit_cut), .fruit_s(fruit_s), .cut_count(cut_count),
    .miss_count(miss_count), .gravity(gravity)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fx(input int i);
    return int'(fruit_x[i*11 +: 11]);
  endfunction

  function automatic int fy(input int i);
    return int'(fruit_y[i*11 +: 11]);
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1;
    launch_valid = 0;
    cut_valid = 0;
    tick();
    Reset = 0;
  endtask

  task automatic launch(input int x, input int vx, input int vy);
    launch_valid = 1;
    launch_x = 11'(x);
    launch_vx = 8'(vx);
    launch_vy = 8'(vy);
    tick();
    launch_valid = 0;
  endtask

  task automatic cut_at(input int x, input int y);
    cut_valid = 1;
    cut_x = 11'(x);
    cut_y = 11'(y);
    tick();
    cut_valid = 0;
  endtask

  task automatic cut_one();
    int w = 0;
    while (!launch_ready && w < 20) begin
      tick();
      w++;
    end
    check("cut_one_ready", int'(launch_ready), 1);
    launch(300, 0, -20);
    cut_at(300, 479);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{0, 0, 1};   vecs[1] = '{4, 4, 1};
    vecs[2] = '{-4, -4, 1}; vecs[3] = '{5, 0, 0};
    vecs[4] = '{0, -5, 0};  vecs[5] = '{-5, 3, 0};
    vecs[6] = '{3, -4, 1};  vecs[7] = '{4, 5, 0};
    Reset = 1; launch_valid = 0; cut_valid = 0;
    launch_x = 0; launch_vx = 0; launch_vy = 0; cut_x = 0; cut_y = 0;
    do_reset();
    check("rst_ready", int'(launch_ready), 1);
    check("rst_active", int'(fruit_active), 0);
    check("rst_cut_cnt", int'(cut_count), 0);
    check("rst_miss_cnt", int'(miss_count), 0);
    check("rst_gravity", int'(gravity), 1);
    check("fruit_s", int'(fruit_s), 4);

    launch(100, 2, -20);
    check("l_x", fx(0), 100);
    check("l_y", fy(0), 479);
    check("l_active", int'(fruit_active), 1);
    tick();
    check("u1_x", fx(0), 102);
    check("u1_y", fy(0), 459);
    repeat (19) tick();
    check("u20_y", fy(0), 269);
    check("u20_x", fx(0), 140);
    tick();
    check("u21_y", fy(0), 269);
    repeat (20) tick();
    check("u41_y", fy(0), 479);
    check("u41_x", fx(0), 182);
    check("u41_active", int'(fruit_active), 1);
    check("u41_miss", int'(miss_count), 0);
    tick();
    check("u42_active", int'(fruit_active), 0);
    check("u42_miss", int'(miss_count), 1);
    check("u42_x_idle", fx(0), 0);
    check("u42_y_idle", fy(0), 0);

    foreach (vecs[i]) begin
      do_reset();
      launch(300, 0, -20);
      cut_at(300 + vecs[i].dx, 479 + vecs[i].dy);
      check($sformatf("box%0d_cut", i), int'(fruit_cut[0]), vecs[i].hit);
      check($sformatf("box%0d_cnt", i), int'(cut_count), vecs[i].hit);
    end

    do_reset();
    repeat (4) launch(300, 0, -10);
    check("full_active", int'(fruit_active), 15);
    check("full_ready", int'(launch_ready), 0);
    launch(50, 0, -10);
    check("fifth_active", int'(fruit_active), 15);
    check("fifth_x0", fx(0), 300);
    check("fifth_x3", fx(3), 300);
    launch_valid = 1;
    cnt = 0;
    while (!launch_ready && cnt < 40) begin
      tick();
      cnt++;
    end
    check("exit_wait", cnt, 18);
    check("exit_active", int'(fruit_active), 14);
    check("exit_miss", int'(miss_count), 1);
    tick();
    launch_valid = 0;
    check("reload_active0", int'(fruit_active[0]), 1);
    check("reload_x0", fx(0), 50);

    do_reset();
    launch(203, 0, -47);
    tick();
    launch(200, 0, -90);
    tick();
    tick();
    check("pair_x0", fx(0), 203);
    check("pair_y0", fy(0), 297);
    check("pair_x1", fx(1), 200);
    check("pair_y1", fy(1), 300);
    cut_at(201, 299);
    check("pair_cut", int'(fruit_cut), 3);
    check("pair_active", int'(fruit_active), 0);
    check("pair_cnt", int'(cut_count), 2);
    check("pair_frz_y0", fy(0), 297);
    repeat (7) tick();
    check("pair_cut7", int'(fruit_cut), 3);
    tick();
    check("pair_cut8", int'(fruit_cut), 0);
    check("pair_idle_x", fx(1), 0);

    do_reset();
    launch(320, 0, 5);
    cut_at(320, 479);
    check("edge_cut", int'(fruit_cut[0]), 1);
    check("edge_miss", int'(miss_count), 0);
    do_reset();
    launch(320, 0, 5);
    tick();
    check("edge_nocut_active", int'(fruit_active), 0);
    check("edge_nocut_miss", int'(miss_count), 1);

    do_reset();
    repeat (8) cut_one();
    check("lvl8_cnt", int'(cut_count), 8);
    check("lvl8_g_before", int'(gravity), 1);
    tick();
    check("lvl8_g", int'(gravity), 2);
    repeat (8) cut_one();
    tick();
    check("lvl16_g", int'(gravity), 3);
    repeat (8) cut_one();
    check("lvl24_cnt", int'(cut_count), 24);
    tick();
    check("lvl24_g", int'(gravity), 4);
    repeat (16) cut_one();
    tick();
    check("lvl40_cnt", int'(cut_count), 40);
    check("lvl40_g", int'(gravity), 4);

    repeat (10) tick();
    repeat (3) launch(300, 0, -20);
    check("pre_rst_active", int'(fruit_active), 7);
    Reset = 1;
    launch_valid = 1;
    cut_valid = 1;
    cut_x = 300;
    cut_y = 479;
    tick();
    Reset = 0;
    launch_valid = 0;
    cut_valid = 0;
    check("mid_rst_active", int'(fruit_active), 0);
    check("mid_rst_cut", int'(fruit_cut), 0);
    check("mid_rst_x", int'(fruit_x != '0), 0);
    check("mid_rst_y", int'(fruit_y != '0), 0);
    check("mid_rst_ready", int'(launch_ready), 1);
    check("mid_rst_cnt", int'(cut_count), 0);
    check("mid_rst_miss", int'(miss_count), 0);
    check("mid_rst_g", int'(gravity), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
